// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlymon.sv
// Delay-line monitor: launches an edge into a delay chain and counts CLK cycles until it returns.
// Optional multi-trial averaging when GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__dlymon #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned AVG_LOG2    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             RET,
    output logic             LAUNCH,
    output logic             BUSY,
    output logic             DONE,
    output logic             TMO,
    output logic [CNT_W-1:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   launch_q, launch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   tmo_q, tmo_d;
    logic                   rs;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   cnt_hit;

`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
    localparam int unsigned ACC_W   = CNT_W + AVG_LOG2;
    localparam int unsigned TRIAL_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TRIAL_W-1:0] trial_q, trial_d;
    logic [ACC_W-1:0]   acc_sum;
    logic               last_trial;

    assign acc_sum    = acc_q + ACC_W'(cnt_q);
    assign last_trial = (trial_q == TRIAL_W'((1 << AVG_LOG2) - 1));
`endif

    assign rs      = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], RET};
    // Saturating increment: the counter parks at TIMEOUT and never wraps.
    assign cnt_inc = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_hit = (cnt_inc == TMO_VAL);

    always_comb begin
        state_d  = state_q;
        launch_d = launch_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        tmo_d    = tmo_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
        acc_d    = acc_q;
        trial_d  = trial_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
                    acc_d   = '0;
                    trial_d = '0;
`endif
                end
            end
            S_ARM: begin
                if (rs == launch_q) begin
                    launch_d = ~launch_q;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_hit) begin
                        state_d  = S_DONE;
                        tmo_d    = 1'b1;
                        result_d = TMO_VAL;
                    end
                end
            end
            S_WAIT: begin
                if (rs == launch_q) begin
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
                    if (last_trial) begin
                        result_d = CNT_W'(acc_sum >> AVG_LOG2);
                        tmo_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = acc_sum;
                        trial_d = trial_q + TRIAL_W'(1);
                        cnt_d   = '0;
                        state_d = S_ARM;
                    end
`else
                    result_d = cnt_q;
                    tmo_d    = 1'b0;
                    state_d  = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_hit) begin
                        state_d  = S_DONE;
                        tmo_d    = 1'b1;
                        result_d = TMO_VAL;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            launch_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            tmo_q    <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
            acc_q    <= '0;
            trial_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            launch_q <= launch_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
            acc_q    <= acc_d;
            trial_q  <= trial_d;
`endif
        end
    end

    assign LAUNCH = launch_q;
    assign BUSY   = (state_q == S_ARM) || (state_q == S_WAIT);
    assign DONE   = (state_q == S_DONE);
    assign TMO    = tmo_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlymon.sv
// Directed bench for the delay-line monitor; RET is modelled as loopback, a tapped delay line or a stuck level.
module tb_gf180mcu_fd_sc_mcu9t5v0__dlymon;

    localparam int unsigned CNT_W = 8;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
    localparam logic FLIP = 1'b0;  // four edges per START bring LAUNCH back to its start level
`else
    localparam logic FLIP = 1'b1;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             RET;
    logic             LAUNCH;
    logic             BUSY;
    logic             DONE;
    logic             TMO;
    logic [CNT_W-1:0] RESULT;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ret_mode = 0;  // 0 loopback, 1 delay line, 2 stuck 0, 3 stuck 1
    int unsigned dly      = 5;
    logic [15:0] line_q   = '0;

    gf180mcu_fd_sc_mcu9t5v0__dlymon #(
        .CNT_W      (8),
        .SYNC_STAGES(2),
        .TIMEOUT    (255),
        .AVG_LOG2   (2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .RET   (RET),
        .LAUNCH(LAUNCH),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .TMO   (TMO),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) line_q <= {line_q[14:0], LAUNCH};

    always @* begin
        case (ret_mode)
            0:       RET = LAUNCH;
            1:       RET = line_q[dly-1];
            2:       RET = 1'b0;
            default: RET = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    // Pulses START for one cycle and waits (bounded) for DONE; lat counts negedges after the START cycle.
    task automatic measure(output logic [CNT_W-1:0] res, output logic tmo, output logic ok,
                           output int unsigned lat);
        ok  = 1'b0;
        res = '0;
        tmo = 1'b0;
        lat = 0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (DONE) begin
                ok  = 1'b1;
                res = RESULT;
                tmo = TMO;
                lat = i;
                break;
            end
            @(negedge CLK);
        end
    endtask

    logic [CNT_W-1:0] res;
    logic             tmo;
    logic             ok;
    int unsigned      lat;
    int unsigned      n_done;
    int unsigned      low;

`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
    int unsigned toggles = 0;
    logic        avg_phase = 1'b0;
    always @(LAUNCH) if (avg_phase) begin
        toggles++;
        dly = (toggles <= 2) ? 3 : 5;
    end
`endif

    initial begin
        START = 1'b0;
        RST   = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_launch", LAUNCH, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_tmo", TMO, 0);
        check("rst_result", RESULT, 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Loopback: result equals synchronizer depth.
        ret_mode = 0;
        measure(res, tmo, ok, lat);
        check("t1_done_seen", ok, 1);
        check("t1_result", res, 2);
        check("t1_tmo", tmo, 0);
        check("t1_launch", LAUNCH, FLIP);
        @(negedge CLK);
        check("t1_done_one_cycle", DONE, 0);
        repeat (5) @(negedge CLK);
        check("t1_result_hold", RESULT, 2);

        // Five-cycle chain, both edges.
        do_reset();
        ret_mode = 1;
        dly      = 5;
        measure(res, tmo, ok, lat);
        check("t2_rise_done", ok, 1);
        check("t2_rise_result", res, 7);
        check("t2_rise_launch", LAUNCH, FLIP);
        repeat (10) @(negedge CLK);
        measure(res, tmo, ok, lat);
        check("t2_fall_done", ok, 1);
        check("t2_fall_result", res, 7);
        check("t2_fall_launch", LAUNCH, 1'b0);

        // Return never arrives: WAIT times out.
        do_reset();
        ret_mode = 2;
        measure(res, tmo, ok, lat);
        check("t3_done", ok, 1);
        check("t3_result", res, 255);
        check("t3_tmo", tmo, 1);
        check("t3_latency", lat, 256);
        check("t3_launch", LAUNCH, 1);

        // Chain never settles: ARM times out without launching.
        do_reset();
        ret_mode = 3;
        measure(res, tmo, ok, lat);
        check("t3b_done", ok, 1);
        check("t3b_result", res, 255);
        check("t3b_tmo", tmo, 1);
        check("t3b_latency", lat, 255);
        check("t3b_launch", LAUNCH, 0);
        do_reset();
        check("rst_clears_tmo", TMO, 0);
        check("rst_clears_result", RESULT, 0);

        // Asynchronous reset mid-WAIT.
        ret_mode = 1;
        dly      = 5;
        START    = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("t4_busy_mid", BUSY, 1);
        check("t4_launch_mid", LAUNCH, 1);
        #2 RST = 1'b1;
        #1;
        check("t4_rst_launch", LAUNCH, 0);
        check("t4_rst_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
        RST    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE) n_done++;
        end
        check("t4_no_done", n_done, 0);
        ret_mode = 0;
        measure(res, tmo, ok, lat);
        check("t4_restart_done", ok, 1);
        check("t4_restart_result", res, 2);

        // START held: BUSY low only for the DONE and IDLE cycles between measurements.
        do_reset();
        ret_mode = 0;
        START    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge CLK);
                if (DONE) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("t5_done", ok, 1);
            check("t5_result", RESULT, 2);
            low = 0;
            while (!BUSY && low < 10) begin
                low++;
                @(negedge CLK);
            end
            check("t5_busy_gap", low, 2);
        end
        START = 1'b0;

`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYMON_AVG_EN
        // Trials with chain delays 3,3,5,5: per-trial 5,5,7,7 -> mean 6.
        do_reset();
        ret_mode  = 1;
        dly       = 3;
        toggles   = 0;
        avg_phase = 1'b1;
        measure(res, tmo, ok, lat);
        check("t6_done", ok, 1);
        check("t6_result", res, 6);
        check("t6_tmo", tmo, 0);
        avg_phase = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
